fifo_wr_arbiter: RTL and testbench

Round-robin, packet-locked write arbiter that shares one fifo write port among N_REQ producers, such as multiple image/feature fetch engines in the cascade classifier.
Once a requester is granted, the grant is held until that requester's end-of-packet beat (eot[0]) or flush beat (eot[1]) is accepted. Packets from different requesters never interleave in the fifo.
The eot field is forwarded unchanged, so a downstream flush still reaches the fifo.

---
 rtl/fifo_wr_arbiter.sv | 111 +++++++++++
 tb/tb_fifo_wr_arbiter.sv | 319 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter: round-robin, packet-locked arbiter sharing one fifo write port among N_REQ producers
module fifo_wr_arbiter #(
    parameter int W_DATA = 8,
    parameter int N_REQ  = 2,
    parameter int W_CNT  = 16,
    localparam int W_ID  = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [N_REQ-1:0]        req_valid,
    output logic [N_REQ-1:0]        req_ready,
    input  logic [N_REQ*W_DATA-1:0] req_data,
    input  logic [N_REQ*2-1:0]      req_eot,
    output logic                    dout_valid,
    input  logic                    dout_ready,
    output logic [W_DATA-1:0]       dout_data,
    output logic [1:0]              dout_eot,
    output logic [W_ID-1:0]         grant_id,
    output logic                    grant_active,
    output logic [W_CNT-1:0]        beat_cnt
);
    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] BUSY = 1'b1;

    logic [0:0]        state_q, state_d;
    logic [W_ID-1:0]   grant_q, grant_d, last_q, last_d, sel;
    logic [W_CNT-1:0]  cnt_q, cnt_d;
    logic              found, busy, own_valid, accept, release_beat;
    logic [W_DATA-1:0] own_data;
    logic [1:0]        own_eot;
    int                t;

    // Round-robin search starting just after the previous owner; only real requester indices are visited
    always_comb begin
        sel = '0;
        found = 1'b0;
        t = 0;
        for (int k = 1; k <= N_REQ; k++) begin
            t = int'(last_q) + k;
            t = (t >= N_REQ) ? t - N_REQ : t;
            for (int i = 0; i < N_REQ; i++) begin
                if (!found && t == i && req_valid[i]) begin
                    found = 1'b1;
                    sel = W_ID'(i);
                end
            end
        end
    end

    // Zero-latency pass-through from the owner; reset forces the handshake outputs low immediately
    always_comb begin
        own_valid = 1'b0;
        own_data = '0;
        own_eot = '0;
        req_ready = '0;
        busy = rst && (state_q == BUSY);
        for (int i = 0; i < N_REQ; i++) begin
            if (int'(grant_q) == i) begin
                own_valid = req_valid[i];
                own_data = req_data[i*W_DATA +: W_DATA];
                own_eot = req_eot[i*2 +: 2];
                req_ready[i] = busy && dout_ready;
            end
        end
        dout_valid = busy && own_valid;
        dout_data = own_data;
        dout_eot = dout_valid ? own_eot : 2'b00;
        accept = dout_valid && dout_ready;
        release_beat = accept && (|own_eot);
        grant_active = busy;
        grant_id = grant_q;
        beat_cnt = cnt_q;
    end

    // Grant on any request while idle, count accepted beats, release on an accepted eot or flush beat
    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        last_d = last_q;
        cnt_d = cnt_q;
        if (state_q == IDLE) begin
            if (found) begin
                state_d = BUSY;
                grant_d = sel;
                cnt_d = '0;
            end
        end else begin
            if (accept)
                cnt_d = (&cnt_q) ? cnt_q : cnt_q + W_CNT'(1);
            if (release_beat) begin
                state_d = IDLE;
                last_d = grant_q;
            end
        end
    end

    // State registers; reset points last_grant at the top index so requester 0 wins first
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            grant_q <= '0;
            last_q <= W_ID'(N_REQ - 1);
            cnt_q <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            last_q <= last_d;
            cnt_q <= cnt_d;
        end
    end
endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// tb_fifo_wr_arbiter: scoreboard bench for the round-robin fifo write arbiter
module tb_fifo_wr_arbiter;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        v [2];
    logic [7:0]  d [2];
    logic [1:0]  e [2];
    logic [1:0]  req_valid, req_ready;
    logic [15:0] req_data;
    logic [3:0]  req_eot;
    logic        dout_valid, dout_ready;
    logic [7:0]  dout_data;
    logic [1:0]  dout_eot;
    logic        grant_id, grant_active;
    logic [15:0] beat_cnt;
    int          pass_cnt = 0;
    int          total_cnt = 0;
    logic [9:0]  exp0 [$];
    logic [9:0]  exp1 [$];
    logic        mid = 1'b0;
    logic        owner = 1'b0;

    always #5 clk = ~clk;

    assign req_valid = {v[1], v[0]};
    assign req_data  = {d[1], d[0]};
    assign req_eot   = {e[1], e[0]};

    fifo_wr_arbiter #(.W_DATA(8), .N_REQ(2), .W_CNT(16)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_data(req_data), .req_eot(req_eot),
        .dout_valid(dout_valid), .dout_ready(dout_ready), .dout_data(dout_data), .dout_eot(dout_eot),
        .grant_id(grant_id), .grant_active(grant_active), .beat_cnt(beat_cnt)
    );

    task automatic monitor();
        logic [9:0] got, want;
        forever begin
            @(negedge clk);
            if (dout_valid && dout_ready) begin
                got = {dout_data, dout_eot};
                total_cnt++;
                if (grant_id == 1'b0 ? exp0.size() == 0 : exp1.size() == 0)
                    $display("FAIL unexpected_beat req%0d data=%h eot=%b required none", grant_id, dout_data, dout_eot);
                else begin
                    want = (grant_id == 1'b0) ? exp0.pop_front() : exp1.pop_front();
                    if (got !== want)
                        $display("FAIL beat req%0d data/eot=%h required %h", grant_id, got, want);
                    else
                        pass_cnt++;
                end
                if (mid) begin
                    total_cnt++;
                    if (grant_id !== owner)
                        $display("FAIL interleave owner=%0d required %0d", grant_id, owner);
                    else
                        pass_cnt++;
                end
                owner = grant_id;
                mid = (dout_eot == 2'b00);
            end
        end
    endtask

    task automatic send_pkt(input logic r, input int n, input logic [7:0] base, input logic [1:0] leot);
        for (int b = 0; b < n; b++) begin
            logic [7:0] dat;
            logic [1:0] eo;
            int t;
            dat = base + 8'(b * 17);
            eo = (b == n - 1) ? leot : 2'b00;
            v[r] = 1'b1;
            d[r] = dat;
            e[r] = eo;
            if (r == 1'b0) exp0.push_back({dat, eo});
            else exp1.push_back({dat, eo});
            t = 0;
            do begin
                @(negedge clk);
                t++;
            end while (!req_ready[r] && t < 200);
            if (!req_ready[r]) begin
                total_cnt++;
                $display("FAIL send_timeout req%0d ready=%b required 1", r, req_ready[r]);
                v[r] = 1'b0;
                return;
            end
            @(posedge clk);
            #1;
        end
        v[r] = 1'b0;
        e[r] = 2'b00;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        v[0] = 1'b1; v[1] = 1'b1; e[0] = 2'b11; e[1] = 2'b11;
        dout_ready = 1'b1;
        repeat (2) @(negedge clk);
        total_cnt++;
        if ({req_ready, dout_valid, dout_eot, grant_active} !== 6'b0)
            $display("FAIL reset_outputs ready/valid/eot/active=%b required 000000", {req_ready, dout_valid, dout_eot, grant_active});
        else pass_cnt++;
        total_cnt++;
        if (beat_cnt !== 16'd0) $display("FAIL reset_beat_cnt beat_cnt=%0d required 0", beat_cnt);
        else pass_cnt++;
        total_cnt++;
        if (grant_id !== 1'b0) $display("FAIL reset_grant_id grant_id=%0d required 0", grant_id);
        else pass_cnt++;
        v[0] = 1'b0; v[1] = 1'b0; e[0] = 2'b00; e[1] = 2'b00;
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_single();
        fork
            send_pkt(1'b0, 3, 8'h11, 2'b01);
            begin
                @(negedge clk);
                total_cnt++;
                if (grant_active !== 1'b0) $display("FAIL arb_latency grant_active=%b required 0", grant_active);
                else pass_cnt++;
                @(negedge clk);
                total_cnt++;
                if ({grant_active, grant_id} !== 2'b10) $display("FAIL single_grant active/id=%b required 10", {grant_active, grant_id});
                else pass_cnt++;
                for (int b = 0; b < 3; b++) begin
                    logic [7:0] w;
                    w = 8'(17 * (b + 1));
                    if (b > 0) @(negedge clk);
                    total_cnt++;
                    if ({dout_valid, dout_data} !== {1'b1, w})
                        $display("FAIL single_stream valid/data=%b/%h required 1/%h", dout_valid, dout_data, w);
                    else pass_cnt++;
                end
            end
        join
        @(negedge clk);
        total_cnt++;
        if ({grant_active, beat_cnt} !== {1'b0, 16'd3})
            $display("FAIL single_done active=%b beat_cnt=%0d required 0/3", grant_active, beat_cnt);
        else pass_cnt++;
    endtask

    task automatic test_round_robin();
        @(posedge clk); #1 rst = 1'b0;
        @(posedge clk); #1 rst = 1'b1;
        fork
            begin send_pkt(1'b0, 2, 8'h40, 2'b01); send_pkt(1'b0, 2, 8'h50, 2'b01); end
            begin send_pkt(1'b1, 2, 8'h60, 2'b01); send_pkt(1'b1, 2, 8'h70, 2'b01); end
            begin
                logic prev;
                int gap, nr;
                prev = 1'b0; gap = 0; nr = 0;
                repeat (30) begin
                    @(negedge clk);
                    if (grant_active && !prev) begin
                        total_cnt++;
                        if (grant_id !== nr[0]) $display("FAIL rr_order grant %0d id=%0d required %0d", nr, grant_id, nr[0]);
                        else pass_cnt++;
                        if (nr > 0) begin
                            total_cnt++;
                            if (gap != 1) $display("FAIL rr_idle_gap gap=%0d required 1", gap);
                            else pass_cnt++;
                        end
                        gap = 0;
                        nr++;
                    end
                    if (!grant_active) gap++;
                    prev = grant_active;
                end
                total_cnt++;
                if (nr != 4) $display("FAIL rr_grant_count count=%0d required 4", nr);
                else pass_cnt++;
            end
        join
    endtask

    task automatic test_backpressure();
        @(posedge clk); #1;
        dout_ready = 1'b0;
        fork
            send_pkt(1'b1, 4, 8'h80, 2'b01);
            begin
                repeat (12) begin @(posedge clk); #1 dout_ready = ~dout_ready; end
                dout_ready = 1'b1;
            end
            begin
                logic held;
                logic [7:0] hd;
                held = 1'b0; hd = 8'h00;
                repeat (12) begin
                    @(negedge clk);
                    total_cnt++;
                    if (req_ready !== (grant_active ? {dout_ready, 1'b0} : 2'b00))
                        $display("FAIL bp_ready_mirror req_ready=%b dout_ready=%b active=%b", req_ready, dout_ready, grant_active);
                    else pass_cnt++;
                    if (held) begin
                        total_cnt++;
                        if ({dout_valid, dout_data} !== {1'b1, hd})
                            $display("FAIL bp_hold valid/data=%b/%h required 1/%h", dout_valid, dout_data, hd);
                        else pass_cnt++;
                    end
                    held = dout_valid && !dout_ready;
                    hd = dout_data;
                end
            end
        join
        total_cnt++;
        if (exp1.size() != 0) $display("FAIL bp_once pending=%0d required 0", exp1.size());
        else pass_cnt++;
    endtask

    task automatic test_flush();
        @(posedge clk); #1;
        dout_ready = 1'b1;
        fork
            send_pkt(1'b1, 1, 8'hF0, 2'b10);
            begin
                int t;
                t = 0;
                do begin @(negedge clk); t++; end while (!dout_valid && t < 20);
                total_cnt++;
                if ({dout_valid, dout_eot} !== 3'b110) $display("FAIL flush_eot valid/eot=%b/%b required 1/10", dout_valid, dout_eot);
                else pass_cnt++;
            end
        join
        @(negedge clk);
        total_cnt++;
        if (grant_active !== 1'b0) $display("FAIL flush_release active=%b required 0", grant_active);
        else pass_cnt++;
        @(posedge clk); #1;
        fork
            send_pkt(1'b0, 1, 8'hA0, 2'b01);
            send_pkt(1'b1, 1, 8'hB0, 2'b01);
            begin
                int t;
                t = 0;
                do begin @(negedge clk); t++; end while (!grant_active && t < 10);
                total_cnt++;
                if ({grant_active, grant_id} !== 2'b10) $display("FAIL flush_next_arb active/id=%b required 10", {grant_active, grant_id});
                else pass_cnt++;
            end
        join
    endtask

    task automatic test_lock();
        @(posedge clk); #1;
        send_pkt(1'b0, 1, 8'hC0, 2'b00);
        fork
            send_pkt(1'b1, 2, 8'hD0, 2'b01);
            begin
                int t;
                repeat (10) begin
                    @(negedge clk);
                    total_cnt++;
                    if ({grant_active, grant_id, req_ready[1]} !== 3'b100)
                        $display("FAIL lock_hold active/id/ready1=%b required 100", {grant_active, grant_id, req_ready[1]});
                    else pass_cnt++;
                end
                @(posedge clk); #1;
                send_pkt(1'b0, 1, 8'hC1, 2'b01);
                t = 0;
                do begin @(negedge clk); t++; end while (!grant_active && t < 10);
                total_cnt++;
                if ({grant_active, grant_id} !== 2'b11) $display("FAIL lock_handover active/id=%b required 11", {grant_active, grant_id});
                else pass_cnt++;
            end
        join
    endtask

    task automatic test_reset_mid_packet();
        int t;
        @(posedge clk); #1;
        send_pkt(1'b0, 2, 8'h30, 2'b00);
        v[0] = 1'b1; d[0] = 8'hCC; e[0] = 2'b00;
        v[1] = 1'b1; d[1] = 8'hDD; e[1] = 2'b01;
        #2;
        total_cnt++;
        if (dout_valid !== 1'b1) $display("FAIL mid_pre_reset dout_valid=%b required 1", dout_valid);
        else pass_cnt++;
        rst = 1'b0;
        #1;
        total_cnt++;
        if ({dout_valid, req_ready, grant_active, dout_eot} !== 6'b0)
            $display("FAIL mid_async_drop valid/ready/active/eot=%b required 000000", {dout_valid, req_ready, grant_active, dout_eot});
        else pass_cnt++;
        dout_ready = 1'b0;
        @(posedge clk); #1 rst = 1'b1;
        t = 0;
        do begin @(negedge clk); t++; end while (!grant_active && t < 10);
        total_cnt++;
        if ({grant_active, grant_id, beat_cnt} !== {2'b10, 16'd0})
            $display("FAIL mid_post_grant active/id=%b beat_cnt=%0d required 10/0", {grant_active, grant_id}, beat_cnt);
        else pass_cnt++;
        v[0] = 1'b0; v[1] = 1'b0;
    endtask

    initial begin
        v[0] = 1'b0; v[1] = 1'b0;
        d[0] = 8'h00; d[1] = 8'h00;
        e[0] = 2'b00; e[1] = 2'b00;
        dout_ready = 1'b1;
        fork monitor(); join_none
        test_reset();
        test_single();
        test_round_robin();
        test_backpressure();
        test_flush();
        test_lock();
        test_reset_mid_packet();
        total_cnt++;
        if (exp0.size() + exp1.size() != 0)
            $display("FAIL scoreboard_drain pending=%0d required 0", exp0.size() + exp1.size());
        else pass_cnt++;
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
